byte_strip_ctrl: RTL and testbench
==================================

// Module: byte_strip_ctrl
// PURPOSE
//  Framing scheduler in front of byte_strip. Accepts a byte stream of packets over valid/ready and emits
//  one symbol per CLK on D/DK. Places STP on lane slot 0, pads and places END/EDB on slot LANES-1,
//  fills gaps with IDL, and inserts periodic SKP ordered sets (COM,SKP,SKP,SKP) between packets.
// PARAMETERS
//  LANES         4     lanes striped downstream; slot counter wraps at LANES-1
//  BITS          8     symbol width
//  MAX_LEN       64    max payload bytes per packet; longer packets are nullified (EDB)
//  SKP_INTERVAL  1180  cycles between SKP ordered-set requests
// PORTS
//  CLK       in   1       clock; all state changes on posedge CLK
//  RESET     in   1       synchronous, active-high reset
//  IN_VALID  in   1       IN_DATA/IN_SOP/IN_EOP valid
//  IN_READY  out  1       byte accepted when IN_VALID & IN_READY
//  IN_DATA   in   BITS    payload byte
//  IN_SOP    in   1       first byte of a packet
//  IN_EOP    in   1       last byte of a packet
//  IN_ABORT  in   1       sampled with the IN_EOP beat; 1 -> close with EDB instead of END
//  D         out  BITS    symbol to byte_strip (registered)
//  DK        out  1       0 = control symbol (STP/SDP/END/EDB/COM/SKP/IDL), 1 = data or PAD byte
//  SLOT      out  2       lane slot of the current D (0..LANES-1); drives striper alignment
//  ERR       out  1       one-cycle pulse: underrun, overlength, or SOP missing/unexpected
// BEHAVIOUR
//  Reset: D=IDL(7C), DK=0, SLOT=0, IN_READY=0, ERR=0, state=IDLE, SKP timer=0, skp_pend=0, len=0.
//  Reset mid-packet abandons the packet; no END/EDB is emitted.
//  SLOT increments every cycle, LANES-1 -> 0. SKP timer counts every cycle. At SKP_INTERVAL-1 it
//  sets skp_pend and wraps to 0.
//  States: IDLE, DATA, PAD, SKIP. D/DK are loaded from next-symbol logic each cycle.
//  IDLE: emit IDL. When the current SLOT==LANES-1:
//    - if skp_pend: go to SKIP. skp_pend has priority over a waiting packet.
//    - else if IN_VALID&IN_SOP: next D=STP(FB), DK=0 at slot 0, go to DATA.
//    - else if IN_VALID&!IN_SOP: drop the beat (IN_READY=1 for 1 cycle), ERR pulse.
//  DATA: IN_READY=1 combinationally. An accepted byte appears on D with DK=1 next cycle at SLOT+1.
//    - The SOP beat is accepted in the cycle D=STP. IN_SOP on a later beat gives ERR; the byte is still data.
//    - len increments per accepted byte. Accepting byte MAX_LEN+1 sets abort_flag and ERR.
//      The byte is discarded; the packet closes as on EOP.
//    - On an IN_EOP beat, or at the overlength close: latch abort_flag|=IN_ABORT and leave DATA.
//      If that byte lands on slot LANES-2, the next symbol is END(FD)/EDB(FE), DK=0 on slot LANES-1,
//      then IDLE. Otherwise go to PAD.
//    - IN_VALID=0 in DATA (underrun): ERR, abort_flag=1, and close as for EOP (the current slot is last).
//  PAD: IN_READY=0. Emit PAD=00, DK=1 until slot LANES-2 is filled, then END/EDB at slot LANES-1,
//    then IDLE. Exactly one END/EDB per STP.
//  SKIP: emit COM(BC) at slot 0, then SKP(1C) at slots 1..LANES-1, all DK=0, then IDLE.
//    Clear skp_pend on COM. A timer expiry during a packet only sets skp_pend.
//  Invariants: STP/SDP only on slot 0; END/EDB only on slot LANES-1; never STP/END with DK=1.
//    A packet of N<=MAX_LEN bytes occupies ceil((N+2)/LANES) lane rounds.
// STRUCTURE
//  byte_strip_pkg: symbol constants STP,SDP,END,EDB,COM,SKP,IDL,PAD; state enum encoding.
//  Sub-module skp_timer (CLK,RESET,CLR -> PEND): interval counter plus sticky pending flag.
//  Remaining logic: FSM, slot counter, length counter, output register.
// TESTING
//  1 Reset 3 cycles, no input -> D=7C DK=0 every cycle, SLOT cycles 0,1,2,3,0; ERR=0.
//  2 2-byte packet A1,A2 (SOP on A1, EOP on A2) -> slots 0..3: FB/0, A1/1, A2/1, FD/0; then IDL.
//  3 5-byte packet, IN_ABORT=1 on EOP -> FB,b1,b2,b3 | b4,b5,00,FE; DK of 00 is 1; ERR=0.
//  4 IN_VALID drops after byte 2 of 6 -> ERR pulse. Bytes pad with 00 to slot 2, EDB at slot 3.
//  5 SKP_INTERVAL=16; SOP arrives while skp_pend=1 -> BC,1C,1C,1C round precedes STP. A timer
//    expiry mid-packet delays SKP until after END.
//  6 65-byte packet, MAX_LEN=64 -> ERR on byte 65; packet ends with EDB at slot 3; byte 65 is never
//    output. RESET asserted mid-DATA -> next cycle D=7C, SLOT=0.

Source files
------------

// File: rtl/byte_strip_pkg.sv
// Shared symbol codes, FSM encoding and small helpers for the byte_strip framing scheduler.
package byte_strip_pkg;

    localparam logic [7:0] SYM_STP = 8'hFB;
    localparam logic [7:0] SYM_SDP = 8'h5C;
    localparam logic [7:0] SYM_END = 8'hFD;
    localparam logic [7:0] SYM_EDB = 8'hFE;
    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_SKP = 8'h1C;
    localparam logic [7:0] SYM_IDL = 8'h7C;
    localparam logic [7:0] SYM_PAD = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAD  = 2'd2,
        ST_SKIP = 2'd3
    } state_e;

    // A nullified packet closes with EDB, a good one with END.
    function automatic logic [7:0] close_sym(input logic abort_i);
        return abort_i ? SYM_EDB : SYM_END;
    endfunction

endpackage

// File: rtl/byte_strip_ctrl_skp_timer.sv
// Free-running SKP interval counter with a sticky request flag.
module skp_timer #(
    parameter int INTERVAL = 1180
) (
    input  logic CLK,
    input  logic RESET,
    input  logic CLR,
    output logic PEND
);
    localparam int CW = $clog2(INTERVAL);

    logic [CW-1:0] cnt_r;
    logic          pend_r;
    logic          expire_s;

    assign expire_s = (cnt_r == CW'(INTERVAL - 1));

    // Interval counter; an expiry coinciding with a clear keeps the request alive.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_r  <= {CW{1'b0}};
            pend_r <= 1'b0;
        end else begin
            cnt_r <= expire_s ? {CW{1'b0}} : cnt_r + CW'(1);
            if (expire_s) begin
                pend_r <= 1'b1;
            end else if (CLR) begin
                pend_r <= 1'b0;
            end else begin
                pend_r <= pend_r;
            end
        end
    end

    assign PEND = pend_r;

endmodule

// File: rtl/byte_strip_ctrl.sv
// Framing scheduler: wraps packets in STP..END/EDB aligned to lane slots, fills with IDL,
// and inserts SKP ordered sets between packets.
module byte_strip_ctrl
    import byte_strip_pkg::*;
#(
    parameter int LANES        = 4,
    parameter int BITS         = 8,
    parameter int MAX_LEN      = 64,
    parameter int SKP_INTERVAL = 1180
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic [BITS-1:0]            IN_DATA,
    input  logic                       IN_SOP,
    input  logic                       IN_EOP,
    input  logic                       IN_ABORT,
    output logic [BITS-1:0]            D,
    output logic                       DK,
    output logic [$clog2(LANES)-1:0]   SLOT,
    output logic                       ERR
);
    localparam int SW = $clog2(LANES);
    localparam int LW = $clog2(MAX_LEN + 2);
    localparam logic [SW-1:0] SLOT_LAST = SW'(LANES - 1);
    localparam logic [SW-1:0] SLOT_PRE  = SW'(LANES - 2);

    state_e          state_r, state_s;
    logic [BITS-1:0] d_r, d_s;
    logic            dk_r, dk_s;
    logic [SW-1:0]   slot_r;
    logic            err_r, err_s;
    logic [LW-1:0]   len_r, len_s;
    logic            abort_r, abort_s;
    logic            ready_s;
    logic            clr_s;
    logic            pend_s;

    skp_timer #(
        .INTERVAL (SKP_INTERVAL)
    ) u_skp_timer (
        .CLK   (CLK),
        .RESET (RESET),
        .CLR   (clr_s),
        .PEND  (pend_s)
    );

    // Next-symbol and next-state selection; all framing decisions look at the slot of the current D.
    always_comb begin
        state_s = state_r;
        d_s     = BITS'(SYM_IDL);
        dk_s    = 1'b0;
        err_s   = 1'b0;
        len_s   = len_r;
        abort_s = abort_r;
        ready_s = 1'b0;
        clr_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (slot_r == SLOT_LAST) begin
                    if (pend_s) begin
                        d_s     = BITS'(SYM_COM);
                        clr_s   = 1'b1;
                        state_s = ST_SKIP;
                    end else if (IN_VALID && IN_SOP) begin
                        d_s     = BITS'(SYM_STP);
                        len_s   = {LW{1'b0}};
                        abort_s = 1'b0;
                        state_s = ST_DATA;
                    end else if (IN_VALID) begin
                        ready_s = 1'b1;
                        err_s   = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                ready_s = 1'b1;
                if (!IN_VALID || (len_r == LW'(MAX_LEN))) begin
                    // Underrun or overlength: nothing new lands, the current slot is the last one filled.
                    err_s   = 1'b1;
                    abort_s = 1'b1;
                    if (slot_r == SLOT_PRE) begin
                        d_s     = BITS'(SYM_EDB);
                        state_s = ST_IDLE;
                    end else begin
                        d_s     = BITS'(SYM_PAD);
                        dk_s    = 1'b1;
                        state_s = ST_PAD;
                    end
                end else begin
                    d_s   = IN_DATA;
                    dk_s  = 1'b1;
                    len_s = len_r + LW'(1);
                    if (IN_SOP && (len_r != {LW{1'b0}})) begin
                        err_s = 1'b1;
                    end else begin
                        err_s = 1'b0;
                    end
                    if (IN_EOP) begin
                        abort_s = abort_r | IN_ABORT;
                        state_s = ST_PAD;
                    end else begin
                        state_s = ST_DATA;
                    end
                end
            end
            ST_PAD: begin
                if (slot_r == SLOT_PRE) begin
                    d_s     = BITS'(close_sym(abort_r));
                    state_s = ST_IDLE;
                end else begin
                    d_s  = BITS'(SYM_PAD);
                    dk_s = 1'b1;
                end
            end
            ST_SKIP: begin
                d_s = BITS'(SYM_SKP);
                if (slot_r == SLOT_PRE) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SKIP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, slot, length and output registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= ST_IDLE;
            d_r     <= BITS'(SYM_IDL);
            dk_r    <= 1'b0;
            slot_r  <= {SW{1'b0}};
            err_r   <= 1'b0;
            len_r   <= {LW{1'b0}};
            abort_r <= 1'b0;
        end else begin
            state_r <= state_s;
            d_r     <= d_s;
            dk_r    <= dk_s;
            slot_r  <= (slot_r == SLOT_LAST) ? {SW{1'b0}} : slot_r + SW'(1);
            err_r   <= err_s;
            len_r   <= len_s;
            abort_r <= abort_s;
        end
    end

    assign IN_READY = ready_s & ~RESET;
    assign D        = d_r;
    assign DK       = dk_r;
    assign SLOT     = slot_r;
    assign ERR      = err_r;

endmodule

// File: tb/tb_byte_strip_ctrl.sv
// Scoreboard bench for byte_strip_ctrl: packet symbols are queued when driven and matched on D/DK/SLOT.
module tb_byte_strip_ctrl;
    import byte_strip_pkg::*;

    localparam int LANES   = 4;
    localparam int MAX_LEN = 64;
    localparam int SKP_I   = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_sop = 1'b0;
    logic       in_eop = 1'b0;
    logic       in_abort = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic [7:0] d;
    logic       dk;
    logic [1:0] slot;
    logic       err;

    int n_chk = 0;
    int n_fail = 0;

    logic [10:0] sb_q[$];
    logic [10:0] exp_v;
    logic [7:0]  pkt_d[1:80];
    logic        rst_q;
    logic        in_pkt = 1'b0;
    logic        sb_off = 1'b0;
    int          cyc_n = 0;
    int          skp_left = 0;
    int          err_cnt = 0;
    int          last_com_n = -100;
    int          last_stp_n = -100;
    int          err0;

    byte_strip_ctrl #(
        .LANES        (LANES),
        .BITS         (8),
        .MAX_LEN      (MAX_LEN),
        .SKP_INTERVAL (SKP_I)
    ) dut (
        .CLK      (clk),
        .RESET    (reset),
        .IN_VALID (in_valid),
        .IN_READY (in_ready),
        .IN_DATA  (in_data),
        .IN_SOP   (in_sop),
        .IN_EOP   (in_eop),
        .IN_ABORT (in_abort),
        .D        (d),
        .DK       (dk),
        .SLOT     (slot),
        .ERR      (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(posedge clk) rst_q <= reset;

    // Output monitor: reset values, slot sequence, SKP sets and scoreboard matching.
    always @(negedge clk) begin
        if (rst_q === 1'b1) begin
            check_val("rst_d", d, SYM_IDL);
            check_val("rst_dk", dk, 0);
            check_val("rst_slot", slot, 0);
            check_val("rst_err", err, 0);
            check_val("rst_ready", in_ready, 0);
            cyc_n = 0;
            skp_left = 0;
            in_pkt = 1'b0;
            last_com_n = -100;
            last_stp_n = -100;
        end else if (rst_q === 1'b0) begin
            cyc_n++;
            check_val("slot", slot, cyc_n % LANES);
            if (err === 1'b1) err_cnt++;
            if (sb_off) begin
                skp_left = 0;
            end else if (skp_left > 0) begin
                check_val("skp", {dk, d}, {1'b0, SYM_SKP});
                skp_left--;
            end else if (dk == 1'b0 && d == SYM_COM) begin
                check_val("com_slot", slot, 0);
                check_val("com_in_pkt", in_pkt, 0);
                skp_left = LANES - 1;
                last_com_n = cyc_n;
            end else if (in_pkt || !(dk == 1'b0 && d == SYM_IDL)) begin
                if (sb_q.size() == 0) begin
                    check_val("extra_sym", {dk, d}, {1'b0, SYM_IDL});
                end else begin
                    exp_v = sb_q.pop_front();
                    check_val("sym", {d, dk, slot}, exp_v);
                    if (exp_v[2] == 1'b0 && exp_v[10:3] == SYM_STP) begin
                        in_pkt = 1'b1;
                        last_stp_n = cyc_n;
                    end else if (exp_v[2] == 1'b0) begin
                        in_pkt = 1'b0;
                    end
                end
            end
        end
    end

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic drive_beat(input logic [7:0] dat, input logic sop, input logic eop, input logic ab);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data = dat;
        in_sop = sop;
        in_eop = eop;
        in_abort = ab;
        for (int t = 0; t < 64 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        check_val("accept", acc, 1);
    endtask

    task automatic fill_random(input int n);
        for (int k = 1; k <= n; k++) pkt_d[k] = 8'($urandom_range(0, 255));
    endtask

    // Queue the expected framing, then drive the beats; stop_after>0 starves the packet after that many bytes.
    task automatic send_pkt(input int n, input logic abort, input int stop_after);
        int nsend, nout, idx;
        logic ab;
        nsend = (stop_after > 0) ? stop_after : n;
        nout  = (stop_after > 0) ? stop_after : ((n > MAX_LEN) ? MAX_LEN : n);
        ab    = abort || (stop_after > 0) || (n > MAX_LEN);
        sb_q.push_back({SYM_STP, 1'b0, 2'd0});
        for (int k = 1; k <= nout; k++) sb_q.push_back({pkt_d[k], 1'b1, 2'(k % LANES)});
        idx = nout + 1;
        while (idx % LANES != LANES - 1) begin
            sb_q.push_back({SYM_PAD, 1'b1, 2'(idx % LANES)});
            idx++;
        end
        sb_q.push_back({(ab ? SYM_EDB : SYM_END), 1'b0, 2'(LANES - 1)});
        for (int k = 1; k <= nsend; k++) drive_beat(pkt_d[k], k == 1, k == n, abort && (k == n));
        in_valid = 1'b0;
        in_sop = 1'b0;
        in_eop = 1'b0;
        in_abort = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && sb_q.size() != 0; t++) @(posedge clk);
        #1;
        check_val("drain", sb_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset(3);
        repeat (6) @(posedge clk);
        #1 check_val("t1_err", err_cnt, 0);

        err0 = err_cnt;
        pkt_d[1] = 8'hA1;
        pkt_d[2] = 8'hA2;
        send_pkt(2, 1'b0, 0);
        drain();
        check_val("t2_err", err_cnt - err0, 0);

        err0 = err_cnt;
        fill_random(5);
        send_pkt(5, 1'b1, 0);
        drain();
        check_val("t3_err", err_cnt - err0, 0);

        err0 = err_cnt;
        fill_random(6);
        send_pkt(6, 1'b0, 2);
        drain();
        check_val("t4_err", err_cnt - err0, 1);

        do_reset(2);
        repeat (17) @(posedge clk);
        #1;
        fill_random(3);
        send_pkt(3, 1'b0, 0);
        drain();
        check_val("t5_skp_before_stp", last_stp_n - last_com_n, 4);
        fill_random(40);
        send_pkt(40, 1'b0, 0);
        drain();
        repeat (8) @(posedge clk);
        #1 check_val("t5_skp_after_end", (last_com_n > last_stp_n), 1);

        err0 = err_cnt;
        fill_random(65);
        send_pkt(65, 1'b0, 0);
        drain();
        check_val("t6_err", err_cnt - err0, 1);

        err0 = err_cnt;
        drive_beat(8'h55, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 check_val("t7_stray_err", err_cnt - err0, 1);

        sb_off = 1'b1;
        fill_random(3);
        drive_beat(pkt_d[1], 1'b1, 1'b0, 1'b0);
        drive_beat(pkt_d[2], 1'b0, 1'b0, 1'b0);
        drive_beat(pkt_d[3], 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        in_valid = 1'b0;
        in_sop = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        sb_q.delete();
        sb_off = 1'b0;
        err0 = err_cnt;
        fill_random(7);
        send_pkt(7, 1'b0, 0);
        drain();
        check_val("t8_err", err_cnt - err0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
